zacore_mem_arbiter: RTL and testbench



---
 rtl/zacore_mem_arbiter_pkg.sv | 26 ++
 rtl/zacore_mem_arb_prio.sv | 40 ++++
 rtl/zacore_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_zacore_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zacore_mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: request payload, owner tag and FSM states.
package zacore_mem_arbiter_pkg;

  localparam int unsigned STREAK_W = 4;

  typedef logic [31:0] addr_t;

  typedef enum logic {
    MEM_OWNER_FETCH,
    MEM_OWNER_DATA
  } mem_owner_t;

  typedef struct packed {
    addr_t       addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_arb_state_t;

endpackage

// File: rtl/zacore_mem_arb_prio.sv
// Grant logic for the memory arbiter: data has priority, bounded by a streak
// counter so a pending fetch is granted after MAX_DATA_STREAK data grants.
module zacore_mem_arb_prio
  import zacore_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_idle,
  input  logic if_req_valid,
  input  logic dm_req_valid,
  output logic grant_fetch,
  output logic grant_data
);

  logic [STREAK_W-1:0] streak;
  logic                at_limit;

  assign at_limit = (streak == STREAK_W'(MAX_DATA_STREAK));

  always_comb begin
    grant_data  = in_idle && dm_req_valid && !(if_req_valid && at_limit);
    grant_fetch = in_idle && if_req_valid && !grant_data;
  end

  // Only IDLE cycles move the counter; REQ/WAIT cycles leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
    end else if (in_idle) begin
      if (!if_req_valid || grant_fetch) begin
        streak <= '0;
      end else if (grant_data && !at_limit) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end

endmodule

// File: rtl/zacore_mem_arbiter.sv
// Shares the single external memory port between fetch and data requesters,
// one outstanding transaction, response routed to the issuing requester.
module zacore_mem_arbiter
  import zacore_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  input  logic        if_kill,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_rdata,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  input  logic [31:0] dm_req_addr,
  input  logic        dm_req_we,
  input  logic [31:0] dm_req_wdata,
  input  logic [3:0]  dm_req_wstrb,
  output logic        dm_rsp_valid,
  output logic [31:0] dm_rsp_rdata,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_we,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata
);

  mem_arb_state_t state, state_nxt;
  mem_owner_t     owner;
  mem_req_t       req_q;
  logic           killed;
  logic           in_idle;
  logic           grant_fetch;
  logic           grant_data;
  logic           rsp_fire;

  assign in_idle = (state == IDLE);

  zacore_mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk          (clk),
    .rst          (rst),
    .in_idle      (in_idle),
    .if_req_valid (if_req_valid),
    .dm_req_valid (dm_req_valid),
    .grant_fetch  (grant_fetch),
    .grant_data   (grant_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    if_req_ready  = grant_fetch;
    dm_req_ready  = grant_data;
    bus_req_valid = 1'b0;
    if_rsp_valid  = 1'b0;
    dm_rsp_valid  = 1'b0;
    rsp_fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_fetch || grant_data) state_nxt = REQ;
      end
      REQ: begin
        bus_req_valid = 1'b1;
        if (bus_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          rsp_fire  = 1'b1;
          state_nxt = IDLE;
          if (owner == MEM_OWNER_DATA) begin
            dm_rsp_valid = 1'b1;
          end else if (!killed && !if_kill) begin
            if_rsp_valid = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign if_rsp_rdata  = if_rsp_valid ? bus_rsp_rdata : '0;
  assign dm_rsp_rdata  = dm_rsp_valid ? bus_rsp_rdata : '0;
  assign bus_req_addr  = req_q.addr;
  assign bus_req_we    = req_q.we;
  assign bus_req_wdata = req_q.wdata;
  assign bus_req_wstrb = req_q.wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= MEM_OWNER_FETCH;
      req_q  <= '0;
      killed <= 1'b0;
    end else begin
      if (grant_data) begin
        owner <= MEM_OWNER_DATA;
        req_q <= '{addr: dm_req_addr, we: dm_req_we, wdata: dm_req_wdata, wstrb: dm_req_wstrb};
      end else if (grant_fetch) begin
        owner <= MEM_OWNER_FETCH;
        req_q <= '{addr: if_req_addr, we: 1'b0, wdata: 32'd0, wstrb: 4'd0};
      end
      // A kill landing on the response cycle is handled combinationally above.
      if (rsp_fire) begin
        killed <= 1'b0;
      end else if (!in_idle && owner == MEM_OWNER_FETCH && if_kill) begin
        killed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Self-checking bench: transaction-level reference model, directed scenarios
// with literal expectations, then constrained-random traffic.
module tb_zacore_mem_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_kill, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_rdata;
  logic        dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid;
  logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_rdata;
  logic [3:0]  dm_req_wstrb;
  logic        bus_req_valid, bus_req_ready, bus_req_we, bus_rsp_valid;
  logic [31:0] bus_req_addr, bus_req_wdata, bus_rsp_rdata;
  logic [3:0]  bus_req_wstrb;

  always #5 clk = ~clk;

  zacore_mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_kill(if_kill), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
    .dm_req_we(dm_req_we), .dm_req_wdata(dm_req_wdata), .dm_req_wstrb(dm_req_wstrb),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr),
    .bus_req_we(bus_req_we), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: one outstanding transaction record plus a streak count.
  bit          m_active, m_accepted, m_killed, m_is_data;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_wstrb;
  int          m_streak;
  string       glog;

  bit e_dgrant, e_fgrant, e_rsp_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_accepted = 0; m_killed = 0; m_is_data = 0;
    m_addr = 0; m_wdata = 0; m_we = 0; m_wstrb = 0; m_streak = 0;
  endtask

  // Compare all outputs against the model, mid-cycle with inputs stable.
  task automatic sample();
    bit idle;
    #4;
    idle      = !m_active;
    e_dgrant  = idle && dm_req_valid && !(if_req_valid && m_streak == MAX);
    e_fgrant  = idle && if_req_valid && !e_dgrant;
    e_rsp_now = m_active && m_accepted && bus_rsp_valid;
    chk("if_req_ready", 32'(if_req_ready), 32'(e_fgrant));
    chk("dm_req_ready", 32'(dm_req_ready), 32'(e_dgrant));
    chk("bus_req_valid", 32'(bus_req_valid), 32'(m_active && !m_accepted));
    chk("bus_req_addr", bus_req_addr, m_addr);
    chk("bus_req_we", 32'(bus_req_we), 32'(m_we));
    chk("bus_req_wdata", bus_req_wdata, m_wdata);
    chk("bus_req_wstrb", 32'(bus_req_wstrb), 32'(m_wstrb));
    chk("dm_rsp_valid", 32'(dm_rsp_valid), 32'(e_rsp_now && m_is_data));
    chk("if_rsp_valid", 32'(if_rsp_valid),
        32'(e_rsp_now && !m_is_data && !m_killed && !if_kill));
    if (e_rsp_now && !m_is_data && !m_killed && !if_kill)
      chk("if_rsp_rdata", if_rsp_rdata, bus_rsp_rdata);
    if (e_rsp_now && m_is_data && !m_we)
      chk("dm_rsp_rdata", dm_rsp_rdata, bus_rsp_rdata);
  endtask

  // Advance the model across the clock edge using the inputs held this cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (e_rsp_now) begin
        m_active = 0;
        m_killed = 0;
      end else if (m_active) begin
        if (!m_accepted && bus_req_ready) m_accepted = 1;
        if (!m_is_data && if_kill) m_killed = 1;
      end
      if (!m_active && !e_rsp_now) begin
        if (!if_req_valid || e_fgrant) m_streak = 0;
        else if (e_dgrant) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
      end
      if (e_dgrant) begin
        m_active = 1; m_accepted = 0; m_killed = 0; m_is_data = 1;
        m_addr = dm_req_addr; m_we = dm_req_we; m_wdata = dm_req_wdata; m_wstrb = dm_req_wstrb;
        glog = {glog, "D"};
      end else if (e_fgrant) begin
        m_active = 1; m_accepted = 0; m_killed = 0; m_is_data = 0;
        m_addr = if_req_addr; m_we = 0; m_wdata = 0; m_wstrb = 0;
        glog = {glog, "F"};
      end
    end
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = 0; if_kill = 0;
    dm_req_valid = 0; dm_req_addr = 0; dm_req_we = 0; dm_req_wdata = 0; dm_req_wstrb = 0;
    bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
  endtask

  initial begin
    model_reset();
    glog = "";
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    sample();
    chk("reset_bus_req_valid", 32'(bus_req_valid), 32'd0);
    chk("reset_bus_req_addr", bus_req_addr, 32'd0);
    chk("reset_if_req_ready", 32'(if_req_ready), 32'd0);
    tick();

    // Fetch only at 0x100.
    if_req_valid = 1; if_req_addr = 32'h100; bus_req_ready = 1;
    sample(); chk("t1_if_ready", 32'(if_req_ready), 32'd1); tick();
    if_req_valid = 0;
    sample();
    chk("t1_bus_valid", 32'(bus_req_valid), 32'd1);
    chk("t1_bus_addr", bus_req_addr, 32'h100);
    tick();
    cyc();
    bus_rsp_valid = 1; bus_rsp_rdata = 32'hDEADBEEF;
    sample();
    chk("t1_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
    chk("t1_if_rsp_rdata", if_rsp_rdata, 32'hDEADBEEF);
    chk("t1_dm_rsp_valid", 32'(dm_rsp_valid), 32'd0);
    tick();
    bus_rsp_valid = 0;

    // Simultaneous fetch and store: store wins.
    if_req_valid = 1; if_req_addr = 32'h300;
    dm_req_valid = 1; dm_req_addr = 32'h200; dm_req_we = 1;
    dm_req_wdata = 32'h12345678; dm_req_wstrb = 4'hF;
    sample();
    chk("t2_dm_ready", 32'(dm_req_ready), 32'd1);
    chk("t2_if_ready", 32'(if_req_ready), 32'd0);
    tick();
    dm_req_valid = 0;
    sample();
    chk("t2_bus_we", 32'(bus_req_we), 32'd1);
    chk("t2_bus_addr", bus_req_addr, 32'h200);
    tick();
    bus_rsp_valid = 1;
    sample(); chk("t2_store_ack", 32'(dm_rsp_valid), 32'd1); tick();
    bus_rsp_valid = 0;
    sample(); chk("t2_fetch_after_ack", 32'(if_req_ready), 32'd1); tick();
    if_req_valid = 0;
    cyc();
    bus_rsp_valid = 1; cyc(); bus_rsp_valid = 0;

    // Both requesters continuously valid.
    glog = "";
    if_req_valid = 1; dm_req_valid = 1; dm_req_we = 0; bus_req_ready = 1;
    for (int i = 0; i < 30; i++) begin
      bus_rsp_valid = m_active && m_accepted;
      bus_rsp_rdata = $urandom;
      sample();
      tick();
      if (e_dgrant) dm_req_addr = $urandom;
      if (e_fgrant) if_req_addr = $urandom;
    end
    checks++;
    if (glog != "DDDDFDDDDF") begin
      failures++;
      $display("FAIL grant_order actual=%s expected=DDDDFDDDDF", glog);
    end
    if_req_valid = 0; dm_req_valid = 0; bus_rsp_valid = 0;
    cyc();

    // Kill during WAIT, then kill coincident with the response.
    for (int k = 0; k < 2; k++) begin
      if_req_valid = 1; if_req_addr = 32'h500 + 32'(k);
      cyc();
      if_req_valid = 0;
      cyc();
      if_kill = 1; bus_rsp_valid = (k == 1);
      if (k == 0) begin
        cyc();
        if_kill = 0; bus_rsp_valid = 1;
      end
      sample(); chk("t4_killed_rsp", 32'(if_rsp_valid), 32'd0); tick();
      if_kill = 0; bus_rsp_valid = 0; if_req_valid = 1;
      sample(); chk("t4_back_idle", 32'(if_req_ready), 32'd1); tick();
      if_req_valid = 0;
      cyc();
      bus_rsp_valid = 1; cyc(); bus_rsp_valid = 0;
    end

    // Data load stalled in REQ with a fetch pending and kill toggled.
    dm_req_valid = 1; dm_req_addr = 32'h400; dm_req_we = 0; bus_req_ready = 0;
    cyc();
    dm_req_valid = 0; if_req_valid = 1; if_req_addr = 32'h600; if_kill = 1;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("t5_bus_valid", 32'(bus_req_valid), 32'd1);
      chk("t5_bus_addr", bus_req_addr, 32'h400);
      chk("t5_no_ready", 32'(if_req_ready | dm_req_ready), 32'd0);
      tick();
    end
    if_kill = 0; bus_req_ready = 1;
    cyc();
    bus_rsp_valid = 1; bus_rsp_rdata = 32'hCAFEF00D;
    sample();
    chk("t5_load_rsp", 32'(dm_rsp_valid), 32'd1);
    chk("t5_load_data", dm_rsp_rdata, 32'hCAFEF00D);
    tick();
    bus_rsp_valid = 0;
    cyc();
    if_req_valid = 0;
    cyc();
    bus_rsp_valid = 1; cyc(); bus_rsp_valid = 0;

    // Reset while in WAIT.
    if_req_valid = 1; if_req_addr = 32'h700;
    cyc();
    if_req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; if_req_valid = 1; if_req_addr = 32'h800;
    sample();
    chk("t6_bus_valid", 32'(bus_req_valid), 32'd0);
    chk("t6_bus_addr", bus_req_addr, 32'd0);
    chk("t6_if_rsp", 32'(if_rsp_valid), 32'd0);
    chk("t6_accept", 32'(if_req_ready), 32'd1);
    tick();
    if_req_valid = 0;
    cyc();
    bus_rsp_valid = 1; cyc(); bus_rsp_valid = 0;

    // Random traffic; requesters hold payload until the model says granted.
    for (int i = 0; i < 3000; i++) begin
      if (!if_req_valid || e_fgrant) begin
        if_req_valid = ($urandom_range(0, 2) != 0);
        if_req_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req_valid || e_dgrant) begin
        dm_req_valid = ($urandom_range(0, 2) != 0);
        dm_req_addr  = $urandom;
        dm_req_we    = 1'($urandom_range(0, 1));
        dm_req_wdata = $urandom;
        dm_req_wstrb = 4'($urandom_range(0, 15));
      end
      if_kill       = ($urandom_range(0, 5) == 0);
      bus_req_ready = ($urandom_range(0, 4) < 3);
      bus_rsp_valid = m_active && m_accepted && ($urandom_range(0, 1) == 1);
      bus_rsp_rdata = $urandom;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
